mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin CPU/loader arbiter driving an asynchronous SRAM
// Two requesters share one SRAM; every access is a fixed-length strobe window followed by a one-cycle ack.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_wdata,
  output logic [15:0] ld_rdata,
  output logic        ld_ack,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_ld_q, last_ld_d;
  logic        gnt_ld_q, gnt_ld_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] ld_rdata_q, ld_rdata_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        ld_ack_q, ld_ack_d;
  logic [19:0] sram_addr_q, sram_addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        bl_n_q, bl_n_d;
  logic        pick_ld;

  // Loader wins only when it is alone or when the CPU had the previous grant.
  assign pick_ld = ld_req && (!cpu_req || !last_ld_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_ld_d   = last_ld_q;
    gnt_ld_d    = gnt_ld_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    cpu_ack_d   = 1'b0;
    ld_ack_d    = 1'b0;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    bl_n_d      = bl_n_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || ld_req) begin
          state_d     = ACCESS;
          cnt_d       = CNT_LOAD;
          gnt_ld_d    = pick_ld;
          last_ld_d   = pick_ld;
          we_d        = pick_ld ? ld_we    : cpu_we;
          addr_d      = pick_ld ? ld_addr  : cpu_addr;
          wdata_d     = pick_ld ? ld_wdata : cpu_wdata;
          sram_addr_d = {4'b0000, addr_d};
          ce_n_d      = 1'b0;
          bl_n_d      = 1'b0;
          oe_n_d      = we_d;
          we_n_d      = !we_d;
          dq_oe_d     = we_d;
          if (we_d) begin
            dq_out_d = wdata_d;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          bl_n_d  = 1'b1;
          dq_oe_d = 1'b0;
          if (gnt_ld_q) begin
            ld_ack_d = 1'b1;
          end else begin
            cpu_ack_d = 1'b1;
          end
          if (!we_q) begin
            if (gnt_ld_q) begin
              ld_rdata_d = sram_dq_in;
            end else begin
              cpu_rdata_d = sram_dq_in;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
          // Release we_n one cycle early so data is held past the write strobe.
          if (we_q && cnt_q == 4'd1) begin
            we_n_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_ld_q   <= 1'b1;
      gnt_ld_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      cpu_rdata_q <= 16'h0000;
      ld_rdata_q  <= 16'h0000;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      sram_addr_q <= 20'h00000;
      dq_out_q    <= 16'h0000;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      bl_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_ld_q   <= last_ld_d;
      gnt_ld_q    <= gnt_ld_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ld_ack_q    <= ld_ack_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      bl_n_q      <= bl_n_d;
    end
  end

  assign cpu_rdata   = cpu_rdata_q;
  assign ld_rdata    = ld_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign ld_ack      = ld_ack_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_ub_n   = bl_n_q;
  assign sram_lb_n   = bl_n_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at WAIT_CYCLES 2 and 15
module tb_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, ld_addr = '0, ld_wdata = '0, sram_dq_in = '0;
  logic [15:0] cpu_rdata, ld_rdata, sram_dq_out;
  logic        cpu_ack, ld_ack, sram_dq_oe;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [19:0] sram_addr;

  logic        f_cpu_req = 1'b0;
  logic [15:0] f_cpu_addr = '0, f_dq_in = '0;
  logic [15:0] f_cpu_rdata, f_ld_rdata, f_dq_out;
  logic        f_cpu_ack, f_ld_ack, f_dq_oe;
  logic        f_ce_n, f_oe_n, f_we_n, f_ub_n, f_lb_n;
  logic [19:0] f_addr;

  mem_arbiter #(.WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  mem_arbiter #(.WAIT_CYCLES(15)) dut15 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(f_cpu_req), .cpu_we(1'b0), .cpu_addr(f_cpu_addr), .cpu_wdata(16'h0000),
    .cpu_rdata(f_cpu_rdata), .cpu_ack(f_cpu_ack),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr(16'h0000), .ld_wdata(16'h0000),
    .ld_rdata(f_ld_rdata), .ld_ack(f_ld_ack),
    .sram_addr(f_addr), .sram_dq_out(f_dq_out), .sram_dq_oe(f_dq_oe),
    .sram_dq_in(f_dq_in), .sram_ce_n(f_ce_n), .sram_oe_n(f_oe_n),
    .sram_we_n(f_we_n), .sram_ub_n(f_ub_n), .sram_lb_n(f_lb_n)
  );

  initial forever #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_ld;
    logic [15:0] cpu_rd;
    logic [15:0] ld_rd;
    int          at;
  } exp_t;

  exp_t q2[$];
  exp_t q15[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Counts strobe cycles over n negedges and checks address/data whenever the SRAM is driven.
  task automatic run_cnt(input logic [19:0] ea, input logic [15:0] ewd, input int n,
                         output int ce, output int oe, output int we, output int dqo);
    ce = 0; oe = 0; we = 0; dqo = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (!sram_ce_n) begin
        ce++;
        chk("sram_addr", sram_addr, ea);
        chk("byte_lanes", {sram_ub_n, sram_lb_n}, 2'b00);
      end
      if (!sram_oe_n) oe++;
      if (!sram_we_n) we++;
      if (sram_dq_oe) begin
        dqo++;
        chk("sram_dq_out", sram_dq_out, ewd);
      end
    end
  endtask

  // Scoreboard monitor: every ack pops one expected completion.
  initial forever begin
    @(negedge Clk);
    if (cpu_ack || ld_ack) begin
      chk("ack_single", cpu_ack & ld_ack, 1'b0);
      if (q2.size() == 0) begin
        chk("ack_expected", 0, 1);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("ack_port", ld_ack, e.is_ld);
        chk("ack_cycle", cyc, e.at);
        chk("cpu_rdata", cpu_rdata, e.cpu_rd);
        chk("ld_rdata", ld_rdata, e.ld_rd);
      end
    end
    if (f_cpu_ack || f_ld_ack) begin
      if (q15.size() == 0) begin
        chk("ack15_expected", 0, 1);
      end else begin
        exp_t e;
        e = q15.pop_front();
        chk("ack15_port", f_ld_ack, e.is_ld);
        chk("ack15_cycle", cyc, e.at);
        chk("ack15_rdata", f_cpu_rdata, e.cpu_rd);
      end
    end
  end

  int ce, oe, we, dqo, k;

  initial begin
    step();
    step();
    @(negedge Clk);
    chk("rst_acks", {cpu_ack, ld_ack}, 2'b00);
    chk("rst_rdata", {cpu_rdata, ld_rdata}, 32'h0);
    chk("rst_addr", sram_addr, 20'h0);
    chk("rst_dq", {sram_dq_oe, sram_dq_out}, 17'h0);
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'h1F);
    chk("rst15_strobes", {f_ce_n, f_oe_n, f_we_n, f_ub_n, f_lb_n}, 5'h1F);
    Reset = 1'b0;

    // CPU write 0x3000 <- 0xBEEF
    step();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h3000; cpu_wdata = 16'hBEEF;
    q2.push_back('{1'b0, 16'h0000, 16'h0000, cyc + 3});
    step(); cpu_req = 0;
    run_cnt(20'h03000, 16'hBEEF, 5, ce, oe, we, dqo);
    chk("wr_ce_low", ce, 2); chk("wr_we_low", we, 1); chk("wr_oe_low", oe, 0); chk("wr_dq_oe", dqo, 2);

    // CPU read 0x3000 -> 0xBEEF
    step();
    sram_dq_in = 16'hBEEF; cpu_req = 1; cpu_we = 0;
    q2.push_back('{1'b0, 16'hBEEF, 16'h0000, cyc + 3});
    step(); cpu_req = 0;
    run_cnt(20'h03000, 16'h0000, 5, ce, oe, we, dqo);
    chk("rd_ce_low", ce, 2); chk("rd_oe_low", oe, 2); chk("rd_we_low", we, 0); chk("rd_dq_oe", dqo, 0);

    // Loader read 0x0002 -> 0x5A5A, CPU rdata must hold
    step();
    sram_dq_in = 16'h5A5A; ld_req = 1; ld_we = 0; ld_addr = 16'h0002;
    q2.push_back('{1'b1, 16'hBEEF, 16'h5A5A, cyc + 3});
    step(); ld_req = 0;
    run_cnt(20'h00002, 16'h0000, 5, ce, oe, we, dqo);
    chk("ldrd_oe_low", oe, 2);

    // Loader write with request and operands changed right after grant
    step();
    sram_dq_in = 16'hDEAD; ld_req = 1; ld_we = 1; ld_addr = 16'h0001; ld_wdata = 16'h1234;
    q2.push_back('{1'b1, 16'hBEEF, 16'h5A5A, cyc + 3});
    step(); ld_req = 0; ld_we = 0; ld_addr = 16'hFFFF; ld_wdata = 16'hFFFF;
    run_cnt(20'h00001, 16'h1234, 5, ce, oe, we, dqo);
    chk("ldwr_ce_low", ce, 2); chk("ldwr_we_low", we, 1); chk("ldwr_dq_oe", dqo, 2);

    // Fresh reset, then both requesters held: CPU, loader, CPU, loader
    step(); Reset = 1;
    step(); Reset = 0;
    @(negedge Clk);
    chk("rst2_rdata", {cpu_rdata, ld_rdata}, 32'h0);
    step();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'h1111;
    ld_req = 1; ld_we = 1; ld_addr = 16'h0020; ld_wdata = 16'h2222;
    k = cyc;
    q2.push_back('{1'b0, 16'h0, 16'h0, k + 3});
    q2.push_back('{1'b1, 16'h0, 16'h0, k + 7});
    q2.push_back('{1'b0, 16'h0, 16'h0, k + 11});
    q2.push_back('{1'b1, 16'h0, 16'h0, k + 15});
    repeat (15) step();
    cpu_req = 0; ld_req = 0;
    repeat (3) step();

    // Reset in the second ACCESS cycle of a CPU write aborts without ack
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 16'h4444;
    step(); cpu_req = 0;
    step(); Reset = 1;
    step(); Reset = 0;
    @(negedge Clk);
    chk("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'h1F);
    chk("abort_dq_oe", sram_dq_oe, 1'b0);
    chk("abort_ack", {cpu_ack, ld_ack}, 2'b00);
    repeat (4) step();
    cpu_req = 1; ld_req = 1;
    q2.push_back('{1'b0, 16'h0, 16'h0, cyc + 3});
    step(); cpu_req = 0; ld_req = 0;
    repeat (5) step();

    // WAIT_CYCLES=15 read
    f_dq_in = 16'hC0DE; f_cpu_req = 1; f_cpu_addr = 16'h0ABC;
    q15.push_back('{1'b0, 16'hC0DE, 16'h0000, cyc + 16});
    step(); f_cpu_req = 0;
    ce = 0; oe = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge Clk);
      if (!f_ce_n) begin
        ce++;
        chk("addr15", f_addr, 20'h00ABC);
      end
      if (!f_oe_n) oe++;
    end
    chk("ce15_low", ce, 15);
    chk("oe15_low", oe, 15);

    for (int i = 0; i < 50 && (q2.size() + q15.size()) != 0; i++) step();
    chk("queue_drained", q2.size() + q15.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
